mux_reg_n: RTL and testbench
============================

# mux_reg_n

Parametrised N-way datapath selector with a single-entry registered output stage and valid/ready handshake. Generalises the fixed 5-input, 32-bit combinational source muxes in the datapath: width, input count and one hard-wired constant slot (the PC+4 increment) are parameters. Sits between operand/PC sources and consuming registers (PC, ALU operand latches) so the selection is captured at a clean boundary and held until the consumer takes it.

## Interface
- WIDTH, 32, data width in bits
- N_IN, 5, number of selectable slots (2..16)
- SEL_W, 3, selector width; must satisfy 2^SEL_W >= N_IN
- CONST_IDX, 1, slot index returning CONST_VAL instead of its data_in lane
- CONST_VAL, 4, constant returned on slot CONST_IDX (zero-extended to WIDTH)

- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- selector  input  SEL_W  slot select, sampled on accept
- data_in  input  N_IN*WIDTH  flattened lanes, lane k = bits [k*WIDTH +: WIDTH]; lane CONST_IDX ignored
- in_valid  input  1  selector/data_in valid this cycle
- in_ready  output  1  stage can accept this cycle
- data_out  output  WIDTH  registered selected value
- out_valid  output  1  data_out holds an unconsumed value
- out_ready  input  1  consumer takes data_out this cycle
- sel_err  output  1  sticky out-of-range-selector flag (see Configuration)

## Operation
- Two states: EMPTY (out_valid=0), FULL (out_valid=1).
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- in_ready = !out_valid || out_ready (pass-through ready; back-to-back throughput 1/cycle).
- Selection on accept: selector == CONST_IDX -> CONST_VAL; selector < N_IN -> lane selector; selector >= N_IN -> lane 0 (default).
- EMPTY + accept -> FULL, data_out loaded.
- FULL + consume, no accept -> EMPTY, data_out holds last value.
- FULL + consume + accept (same cycle) -> stays FULL, data_out loaded with new selection.
- FULL + no consume -> hold; in_ready=0, inputs ignored even if in_valid=1.
- data_out only changes on accept; never glitches on selector/data_in changes while held.

## Timing
- Reset values: data_out=0, out_valid=0, sel_err=0, state EMPTY; in_ready=1 during and after reset.
- Latency: accept in cycle t -> data_out/out_valid visible after edge t, i.e. cycle t+1.
- reset asserted mid-transfer: held value discarded, out_valid drops asynchronously; no accept on the edge reset deasserts if reset still high at that edge.
- in_ready is combinational from out_valid and out_ready only; no path from in_valid to in_ready.
- Selector and data_in need only be stable around the accepting edge.

## Configuration
- MUX_REG_SEL_ERR_EN defined: sel_err set on any accept with selector >= N_IN; stays 1 until reset. Selected value still lane 0.
- Not defined: sel_err tied to 0, no flag register synthesised; out-of-range still selects lane 0.

## Structure
- Shared package mux_pkg: state enum (MUX_EMPTY, MUX_FULL), default PC increment constant (4), default width 32.
- One sub-module mux_sel_comb: purely combinational N_IN-way select with constant slot and lane-0 default; mux_reg_n instantiates it and owns state, handshake and sel_err.
- Elaboration check: error if 2^SEL_W < N_IN or CONST_IDX >= N_IN.

## Test plan
- Reset then selector=1, in_valid=1, out_ready=1 -> next cycle data_out=32'd4, out_valid=1.
- Lanes 0,2,3,4 = 0xA0,0xA2,0xA3,0xA4; select 3 with out_ready=0 -> data_out=0xA3 held; in_ready=0; new request select 2 ignored until out_ready=1.
- Streaming: selectors 0,2,4 on consecutive cycles, out_ready=1 -> data_out 0xA0,0xA2,0xA4 on consecutive cycles, in_ready never drops.
- selector=7 (N_IN=5) -> data_out=0xA0; with MUX_REG_SEL_ERR_EN sel_err=1 and stays 1 through later valid selects; without macro sel_err=0.
- FULL holding 0xA3, assert reset mid-cycle -> out_valid=0, data_out=0, sel_err=0 immediately, before next clk edge.
- WIDTH=8, N_IN=3, CONST_IDX=2, CONST_VAL=1 -> select 2 returns 8'h01, select 3 returns lane 0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared types and defaults for the registered source selector.
// Optional sticky selector-error flag is enabled by MUX_REG_SEL_ERR_EN.
package mux_pkg;

  typedef enum logic {
    MUX_EMPTY = 1'b0,
    MUX_FULL  = 1'b1
  } mux_state_e;

  localparam int unsigned PC_INC    = 4;
  localparam int          DEF_WIDTH = 32;

  function automatic bit sel_cfg_ok(
    input int sel_w,
    input int n_in,
    input int cidx
  );
    return (n_in >= 2) && (n_in <= 16)
      && ((1 << sel_w) >= n_in)
      && (cidx >= 0) && (cidx < n_in);
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// mux_sel_comb: combinational N-way lane select with one constant slot.
// Out-of-range selectors fall back to lane 0.
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          N_IN      = 5,
  parameter int          SEL_W     = 3,
  parameter int          CONST_IDX = 1,
  parameter int unsigned CONST_VAL = PC_INC
) (
  input  logic [SEL_W-1:0]      selector,
  input  logic [N_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]      sel_out
);

  logic [31:0] sel32;

  assign sel32 = 32'(selector);

  always_comb begin
    sel_out = data_in[0 +: WIDTH];
    for (int k = 1; k < N_IN; k++) begin
      if (sel32 == 32'(k)) begin
        sel_out = data_in[k*WIDTH +: WIDTH];
      end
    end
    if (sel32 == 32'(CONST_IDX)) begin
      sel_out = WIDTH'(CONST_VAL);
    end
  end

endmodule

// File: rtl/mux_reg_n.sv
// mux_reg_n: N-way source selector with a single-entry registered output.
// Define MUX_REG_SEL_ERR_EN to build the sticky out-of-range flag.
module mux_reg_n
  import mux_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          N_IN      = 5,
  parameter int          SEL_W     = 3,
  parameter int          CONST_IDX = 1,
  parameter int unsigned CONST_VAL = PC_INC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      selector,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  if (!sel_cfg_ok(SEL_W, N_IN, CONST_IDX)) begin : g_bad_cfg
    $error("mux_reg_n: bad SEL_W/N_IN/CONST_IDX");
  end

  mux_state_e       state;
  logic [WIDTH-1:0] sel_val;
  logic             accept;

  mux_sel_comb #(
    .WIDTH     (WIDTH),
    .N_IN      (N_IN),
    .SEL_W     (SEL_W),
    .CONST_IDX (CONST_IDX),
    .CONST_VAL (CONST_VAL)
  ) u_sel (
    .selector (selector),
    .data_in  (data_in),
    .sel_out  (sel_val)
  );

  assign out_valid = (state == MUX_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // data_out only moves on accept, so it never tracks held-time input churn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MUX_EMPTY;
      data_out <= '0;
    end else begin
      unique case (state)
        MUX_EMPTY: begin
          if (accept) begin
            state    <= MUX_FULL;
            data_out <= sel_val;
          end
        end
        MUX_FULL: begin
          if (accept) begin
            data_out <= sel_val;
          end else if (out_ready) begin
            state <= MUX_EMPTY;
          end
        end
        default: state <= MUX_EMPTY;
      endcase
    end
  end

`ifdef MUX_REG_SEL_ERR_EN
  logic err_q;
  logic oob;

  assign oob = 32'(selector) >= 32'(N_IN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && oob) begin
      err_q <= 1'b1;
    end
  end

  assign sel_err = err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_reg_n.sv
// tb_mux_reg_n: scoreboard bench for mux_reg_n, default and 8-bit builds.
// Expected values come from a lane-array reference model and a queue.
module tb_mux_reg_n;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   selector;
  logic [31:0]  lane [5];
  logic [159:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  data_out;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;

  logic [1:0]  sel2;
  logic [23:0] data_in2;
  logic        v2, r2, rdy2, ov2, err2;
  logic [7:0]  data_out2;

  int total = 0;
  int bad   = 0;
  logic [31:0] q[$];
  bit err_seen;

`ifdef MUX_REG_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < 5; k++) data_in[k*32 +: 32] = lane[k];
  end

  mux_reg_n dut (
    .clk       (clk),
    .reset     (reset),
    .selector  (selector),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  mux_reg_n #(
    .WIDTH(8), .N_IN(3), .SEL_W(2), .CONST_IDX(2), .CONST_VAL(1)
  ) dut8 (
    .clk       (clk),
    .reset     (reset),
    .selector  (sel2),
    .data_in   (data_in2),
    .in_valid  (v2),
    .in_ready  (rdy2),
    .data_out  (data_out2),
    .out_valid (ov2),
    .out_ready (r2),
    .sel_err   (err2)
  );

  // slot 1 is the PC increment, 0..4 are lanes, anything else is lane 0
  function automatic logic [31:0] ref_pick(int s);
    if (s == 1) return 32'd4;
    if (s < 5) return lane[s];
    return lane[0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, int s, bit r);
    @(negedge clk);
    in_valid  = v;
    selector  = 3'(s);
    out_ready = r;
  endtask

  // issue side: record what an accepted request must eventually produce
  always @(negedge clk) begin
    #2;
    if (!reset && in_valid && in_ready) begin
      q.push_back(ref_pick(int'(selector)));
      if (selector >= 3'd5) err_seen = 1'b1;
    end
  end

  // monitor: compare at the cycle the consumer takes data_out
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      chk("sel_err", 32'(sel_err), 32'(ERR_EN && err_seen));
      if (out_valid && out_ready && q.size() != 0)
        chk("data_out", data_out, q.pop_front());
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    selector  = '0;
    out_ready = 1'b0;
    err_seen  = 1'b0;
    lane[0] = 32'hA0; lane[1] = 32'hFF; lane[2] = 32'hA2;
    lane[3] = 32'hA3; lane[4] = 32'hA4;
    sel2 = '0; data_in2 = '0; v2 = 1'b0; r2 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    drive(1, 1, 1);
    drive(0, 0, 1);
    #3 chk("pc_inc", data_out, 32'd4);

    drive(1, 3, 0);
    repeat (3) begin
      drive(1, 2, 0);
      #3;
      chk("hold_data", data_out, 32'hA3);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    drive(1, 2, 1);
    drive(0, 0, 1);

    drive(1, 0, 1);
    drive(1, 2, 1);
    drive(1, 4, 1);
    drive(0, 0, 1);

    drive(1, 7, 1);
    #3 chk("oob_ready", 32'(in_ready), 32'd1);
    drive(1, 0, 1);
    #3 chk("oob_lane0", data_out, 32'hA0);
    drive(0, 0, 1);

    drive(1, 3, 0);
    drive(0, 0, 0);
    #3 chk("pre_rst", data_out, 32'hA3);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", data_out, 32'd0);
    chk("arst_err", 32'(sel_err), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    q.delete();
    err_seen = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    data_in2 = {8'h33, 8'h22, 8'h5A};
    sel2 = 2'd2; v2 = 1'b1; r2 = 1'b1;
    @(negedge clk);
    sel2 = 2'd3;
    #1;
    chk("w8_const", 32'(data_out2), 32'h01);
    chk("w8_valid", 32'(ov2), 32'd1);
    @(negedge clk);
    v2 = 1'b0;
    #1 chk("w8_oob", 32'(data_out2), 32'h5A);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 4) != 0;
      selector  = 3'($urandom_range(0, 7));
      out_ready = ($urandom % 3) != 0;
      for (int k = 0; k < 5; k++) lane[k] = $urandom;
    end

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
    #3 chk("drain", 32'(q.size()), 32'd0);

    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
